// File: rtl/cpu_pkg.sv
// Shared constants and FSM state encoding for the program-counter stage.
package cpu_pkg;

    localparam int          BIT_WIDTH = 32;
    localparam int          CNT_WIDTH = 32;
    localparam logic [31:0] START_PC  = 32'h40;
    localparam int          PC_INC    = 4;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pc_next_unit.sv
// Program-counter stage: boot/run/halt sequencing, next-PC selection and
// saturating debug counters for retired instructions and taken branches.
module pc_next_unit #(
    parameter int                   BIT_WIDTH = cpu_pkg::BIT_WIDTH,
    parameter logic [BIT_WIDTH-1:0] START_PC  = BIT_WIDTH'(cpu_pkg::START_PC),
    parameter int                   CNT_WIDTH = cpu_pkg::CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 imemRdy,
    input  logic                 isBranch,
    input  logic                 isJal,
    input  logic                 halt,
    input  logic                 compTrue,
    input  logic [BIT_WIDTH-1:0] brOffset,
    input  logic [BIT_WIDTH-1:0] jalTarget,
    output logic [BIT_WIDTH-1:0] pc,
    output logic [BIT_WIDTH-1:0] pcPlus4,
    output logic                 instValid,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] retireCount,
    output logic [CNT_WIDTH-1:0] brTakenCount,
    output cpu_pkg::state_t      state
);

    import cpu_pkg::*;

    state_t               state_q;
    state_t               state_d;
    logic [BIT_WIDTH-1:0] pc_d;
    logic [BIT_WIDTH-1:0] br_target;
    logic [BIT_WIDTH-1:0] jal_pc;
    logic                 commit;
    logic                 br_inc;
    logic                 unused_bits;

    // Word-granular targets: offsets are in words, JAL target's low bits dropped.
    assign pcPlus4   = pc + BIT_WIDTH'(PC_INC);
    assign br_target = pcPlus4 + {brOffset[BIT_WIDTH-3:0], 2'b00};
    assign jal_pc    = {jalTarget[BIT_WIDTH-1:2], 2'b00};

    assign unused_bits = ^{jalTarget[1:0], brOffset[BIT_WIDTH-1:BIT_WIDTH-2]};

    always_comb begin
        state_d   = state_q;
        instValid = 1'b0;
        case (state_q)
            S_BOOT: state_d = S_RUN;
            S_RUN: begin
                instValid = imemRdy;
                if (imemRdy && halt) begin
                    state_d = S_HALT;
                end
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_BOOT;
        endcase
    end

    // A committing halt leaves pc pointing at the halt instruction.
    assign commit = instValid && !halt;
    assign br_inc = instValid && isBranch && compTrue && !isJal;

    always_comb begin
        pc_d = pc;
        if (commit) begin
            if (isJal) begin
                pc_d = jal_pc;
            end else if (isBranch && compTrue) begin
                pc_d = br_target;
            end else begin
                pc_d = pcPlus4;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_BOOT;
            pc      <= START_PC;
        end else begin
            state_q <= state_d;
            pc      <= pc_d;
        end
    end

    assign halted = (state_q == S_HALT);
    assign state  = state_q;

    sat_counter #(.WIDTH(CNT_WIDTH)) u_retire_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (instValid),
        .count (retireCount)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_br_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (br_inc),
        .count (brTakenCount)
    );

endmodule

// File: tb/tb_pc_next_unit.sv
// Directed bench for pc_next_unit with a cycle-level reference model and literal checkpoints.
module tb_pc_next_unit;

    localparam int TB_CW = 4;

    logic              clk;
    logic              reset;
    logic              imemRdy;
    logic              isBranch;
    logic              isJal;
    logic              halt;
    logic              compTrue;
    logic [31:0]       brOffset;
    logic [31:0]       jalTarget;
    logic [31:0]       pc;
    logic [31:0]       pcPlus4;
    logic              instValid;
    logic              halted;
    logic [TB_CW-1:0]  retireCount;
    logic [TB_CW-1:0]  brTakenCount;
    cpu_pkg::state_t   state;

    int errors = 0;
    int checks = 0;
    bit check_en = 1'b0;

    // Reference model: architectural view only.
    logic [31:0]      m_pc;
    bit               m_booting;
    bit               m_stopped;
    logic [TB_CW-1:0] m_ret;
    logic [TB_CW-1:0] m_br;

    pc_next_unit #(.CNT_WIDTH(TB_CW)) dut (
        .clk          (clk),
        .reset        (reset),
        .imemRdy      (imemRdy),
        .isBranch     (isBranch),
        .isJal        (isJal),
        .halt         (halt),
        .compTrue     (compTrue),
        .brOffset     (brOffset),
        .jalTarget    (jalTarget),
        .pc           (pc),
        .pcPlus4      (pcPlus4),
        .instValid    (instValid),
        .halted       (halted),
        .retireCount  (retireCount),
        .brTakenCount (brTakenCount),
        .state        (state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            m_pc      = 32'h40;
            m_booting = 1'b1;
            m_stopped = 1'b0;
            m_ret     = '0;
            m_br      = '0;
        end else if (m_booting) begin
            m_booting = 1'b0;
        end else if (!m_stopped && imemRdy) begin
            if (m_ret != {TB_CW{1'b1}}) m_ret = m_ret + 1'b1;
            if (isBranch && compTrue && !isJal && m_br != {TB_CW{1'b1}}) m_br = m_br + 1'b1;
            if (halt) m_stopped = 1'b1;
            else if (isJal) m_pc = jalTarget & 32'hFFFF_FFFC;
            else if (isBranch && compTrue) m_pc = m_pc + 32'd4 + brOffset * 32'd4;
            else m_pc = m_pc + 32'd4;
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("pc", pc, m_pc);
            chk("pcPlus4", pcPlus4, m_pc + 32'd4);
            chk("instValid", 32'(instValid), 32'(!m_booting && !m_stopped && imemRdy));
            chk("halted", 32'(halted), 32'(m_stopped));
            chk("retireCount", 32'(retireCount), 32'(m_ret));
            chk("brTakenCount", 32'(brTakenCount), 32'(m_br));
            chk("pc_align", 32'(pc[1:0]), 32'd0);
        end
    end

    task automatic drive(input logic rdy, input logic br, input logic jal, input logic hlt,
                         input logic cmp, input logic [31:0] off, input logic [31:0] tgt,
                         input int n);
        imemRdy   = rdy;
        isBranch  = br;
        isJal     = jal;
        halt      = hlt;
        compTrue  = cmp;
        brOffset  = off;
        jalTarget = tgt;
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            #1;
        end
    endtask

    initial begin
        reset = 1'b1;
        imemRdy = 1'b0; isBranch = 1'b0; isJal = 1'b0; halt = 1'b0; compTrue = 1'b0;
        brOffset = '0; jalTarget = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_en = 1'b1;
        #1;
        chk("lit_reset_pc", pc, 32'h40);
        chk("lit_reset_halted", 32'(halted), 32'd0);
        chk("lit_reset_ret", 32'(retireCount), 32'd0);

        // Boot cycle ignores imemRdy.
        reset = 1'b0;
        imemRdy = 1'b1;
        #1;
        chk("lit_boot_instValid", 32'(instValid), 32'd0);
        drive(1, 0, 0, 0, 0, 32'd0, 32'd0, 1);
        chk("lit_boot_pc", pc, 32'h40);

        drive(1, 0, 0, 0, 0, 32'd0, 32'd0, 3);
        chk("lit_seq_pc", pc, 32'h4C);
        chk("lit_seq_ret", 32'(retireCount), 32'd3);

        drive(1, 1, 0, 0, 1, 32'hFFFF_FFFE, 32'd0, 1);
        chk("lit_br_taken_pc", pc, 32'h48);
        chk("lit_br_taken_cnt", 32'(brTakenCount), 32'd1);
        drive(1, 1, 0, 0, 0, 32'hFFFF_FFFE, 32'd0, 1);
        chk("lit_br_not_taken_pc", pc, 32'h4C);
        chk("lit_br_not_taken_cnt", 32'(brTakenCount), 32'd1);

        imemRdy = 1'b1; isBranch = 1'b1; isJal = 1'b1; compTrue = 1'b1; jalTarget = 32'h103;
        #1;
        chk("lit_jal_link", pcPlus4, 32'h50);
        drive(1, 1, 1, 0, 1, 32'hFFFF_FFFE, 32'h103, 1);
        chk("lit_jal_pc", pc, 32'h100);
        chk("lit_jal_brcnt", 32'(brTakenCount), 32'd1);
        chk("lit_jal_ret", 32'(retireCount), 32'd6);

        drive(0, 0, 1, 0, 0, 32'd0, 32'h200, 5);
        chk("lit_stall_pc", pc, 32'h100);
        chk("lit_stall_ret", 32'(retireCount), 32'd6);

        drive(1, 0, 1, 0, 0, 32'd0, 32'hFFFF_FFFE, 1);
        chk("lit_jal_top_pc", pc, 32'hFFFF_FFFC);
        drive(1, 0, 0, 0, 0, 32'd0, 32'd0, 1);
        chk("lit_wrap_pc", pc, 32'h0);

        drive(1, 1, 0, 0, 1, 32'd3, 32'd0, 1);
        chk("lit_fwd_br_pc", pc, 32'h10);

        drive(1, 0, 0, 1, 0, 32'd0, 32'd0, 1);
        chk("lit_halted", 32'(halted), 32'd1);
        chk("lit_halt_pc", pc, 32'h10);
        drive(1, 1, 1, 0, 1, 32'd5, 32'h300, 10);
        chk("lit_halt_hold_pc", pc, 32'h10);
        chk("lit_halt_hold_ret", 32'(retireCount), 32'd10);

        reset = 1'b1;
        drive(1, 0, 0, 0, 0, 32'd0, 32'd0, 1);
        chk("lit_rst_halt_pc", pc, 32'h40);
        chk("lit_rst_halt_halted", 32'(halted), 32'd0);
        chk("lit_rst_halt_ret", 32'(retireCount), 32'd0);
        chk("lit_rst_halt_br", 32'(brTakenCount), 32'd0);

        // Branch-to-self loop drives both counters into saturation.
        reset = 1'b0;
        drive(1, 1, 0, 0, 1, 32'hFFFF_FFFF, 32'd0, 22);
        chk("lit_sat_ret", 32'(retireCount), 32'd15);
        chk("lit_sat_br", 32'(brTakenCount), 32'd15);
        chk("lit_sat_pc", pc, 32'h40);

        drive(0, 0, 0, 0, 0, 32'd0, 32'd0, 1);
        check_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
